lab2_proc_muldiv_iter: RTL and testbench
========================================

LAB2_PROC_MULDIV_ITER -- requirements
Module: lab2_proc_muldiv_iter

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits.
REQ-002 Clocking: the block SHALL use one clock, and reset SHALL be synchronous and active-high.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_val  input  1  request valid.
REQ-006 req_rdy  output  1  block can accept a request.
REQ-007 req_msg  input  67  {fn[66:64], a[63:32], b[31:0]}; fn: 0=MUL, 1=DIV, 2=DIVU, 3=REM, 4=REMU, 5..7 reserved.
REQ-008 resp_val  output  1  result valid.
REQ-009 resp_rdy  input  1  consumer accepts result.
REQ-010 resp_msg  output  32  result word.

Function
REQ-011 The request transfer SHALL occur only on a cycle with req_val && req_rdy; the response transfer SHALL occur only on a cycle with resp_val && resp_rdy.
REQ-012 States:
- IDLE: req_rdy=1, resp_val=0.
- CALC: req_rdy=0, resp_val=0.
- DONE: req_rdy=0, resp_val=1.
REQ-013 Transitions:
- IDLE->CALC on a request transfer; operands, fn and signs are latched in the same cycle.
- CALC->DONE after exactly 32 iteration cycles, counted by a 5-bit counter that starts at 0 and exits at 31.
- DONE->IDLE on a response transfer.
- DONE holds, with resp_msg stable, while resp_rdy=0.
REQ-014 Latency: request accepted in cycle N SHALL produce resp_val=1 in cycle N+33; back-to-back throughput is one operation per 34 cycles minimum.
REQ-015 There SHALL be no combinational path from req_val to req_rdy or from resp_rdy to resp_val.
REQ-016 MUL: radix-2 shift-add, one multiplier bit per cycle; result is the low 32 bits of a*b, identical for signed and unsigned interpretation.
REQ-017 DIVU/REMU: restoring division, one quotient bit per cycle, using a 33-bit partial-remainder subtractor.
REQ-018 DIV/REM: operands are converted to magnitudes at accept time. The quotient is negated when the operand signs differ. The remainder takes the sign of a (truncating division).
REQ-019 Divide by zero (b=0):
- DIV/DIVU SHALL return 0xFFFFFFFF.
- REM/REMU SHALL return a.
- The block SHALL still take the full 32-cycle latency.
REQ-020 Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV SHALL return 0x80000000 and REM SHALL return 0.
REQ-021 Reserved fn: the block SHALL follow the normal latency and return 0.
REQ-022 req_val asserted while in CALC or DONE SHALL be ignored, with no state change.

Reset
REQ-023 On reset, the block SHALL enter IDLE with req_rdy=1, resp_val=0, resp_msg=0 and the counter cleared, effective the cycle after reset is sampled high.
REQ-024 Reset asserted in CALC or DONE SHALL abandon the operation; no response for it SHALL ever appear.
REQ-025 Operand and accumulator registers need not be reset; outputs SHALL not depend on their values while in IDLE.

Structure
REQ-026 A shared package SHALL hold:
- the fn encodings (MULDIV_MUL ... MULDIV_REMU);
- the state enum (IDLE, CALC, DONE);
- the request-message field offsets.
REQ-027 The block SHALL be split into a control unit (FSM, counter, handshake) and a datapath sub-module lab2_proc_muldiv_iter_dpath (operand registers, shifter, adder/subtractor, sign fixup), joined by control/status signals.
REQ-028 The block SHALL reuse codebase arithmetic/register primitives (enable registers, adders, equality comparator) where they fit.

Verification
REQ-029 MUL a=0xFFFFFFFF (-1), b=7, resp_rdy=1 -> resp_val rises exactly 33 cycles after accept; resp_msg=0xFFFFFFF9.
REQ-030 DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU a=0xFFFFFFF9, b=2 -> 0x7FFFFFFC.
REQ-031 DIV/REM/DIVU/REMU with b=0, a=0x12345678 -> 0xFFFFFFFF, 0x12345678, 0xFFFFFFFF, 0x12345678; DIV a=0x80000000, b=-1 -> 0x80000000 and REM -> 0.
REQ-032 Backpressure check:
- Stimulus: hold resp_rdy=0 for 10 cycles in DONE while req_val stays asserted with a second request.
- Required response: resp_val and resp_msg stay stable, req_rdy=0, and the second request is accepted only in the cycle after the response transfer.
REQ-033 Reset check:
- Stimulus: assert reset at iteration 15 of a DIV.
- Required response: the next cycle shows req_rdy=1 and resp_val=0; a following MUL 3*5 returns 15 with normal latency.
REQ-034 Random check: 1000 random fn/operand pairs with random req_val/resp_rdy stalls, compared against a golden model, with zero mismatches and no dropped or duplicated responses.

Source files
------------

// File: rtl/lab2_proc_muldiv_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: widths, fn codes,
// FSM states and request-message field offsets.
package lab2_proc_muldiv_iter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned FN_W   = 3;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned MSG_W  = FN_W + 2 * DATA_W;

  localparam int unsigned B_LSB  = 0;
  localparam int unsigned A_LSB  = DATA_W;
  localparam int unsigned FN_LSB = 2 * DATA_W;

  typedef enum logic [FN_W-1:0] {
    MULDIV_MUL  = 3'd0,
    MULDIV_DIV  = 3'd1,
    MULDIV_DIVU = 3'd2,
    MULDIV_REM  = 3'd3,
    MULDIV_REMU = 3'd4
  } muldiv_fn_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Two's-complement negate when neg is set, pass-through otherwise.
  function automatic logic [DATA_W-1:0] cond_neg(input logic neg, input logic [DATA_W-1:0] x);
    return neg ? (~x + DATA_W'(1)) : x;
  endfunction

endpackage

// File: rtl/lab2_proc_muldiv_iter_dpath.sv
// Datapath: operand/accumulator registers, shift-add multiply step, restoring
// divide step, sign fixup and the registered result word.
module lab2_proc_muldiv_iter_dpath
  import lab2_proc_muldiv_iter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [MSG_W-1:0]  req_msg,
  input  logic              load_c,
  input  logic              step_c,
  input  logic              last_c,
  output logic [DATA_W-1:0] resp_msg
);

  logic [FN_W-1:0]   fn_in;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic              signed_op;
  logic              a_neg;
  logic              b_neg;

  // a_reg: multiplicand (MUL) or dividend shifting into quotient (DIV/REM)
  // b_reg: multiplier shifting right (MUL) or divisor magnitude (DIV/REM)
  // acc_reg: product (MUL) or partial remainder (DIV/REM)
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [DATA_W-1:0] acc_reg;
  logic [FN_W-1:0]   fn_reg;
  logic              neg_q;
  logic              neg_r;
  logic              b_zero;

  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   sub;
  logic [DATA_W-1:0] a_nxt;
  logic [DATA_W-1:0] b_nxt;
  logic [DATA_W-1:0] acc_nxt;
  logic [DATA_W-1:0] result_nxt;

  assign fn_in     = req_msg[FN_LSB +: FN_W];
  assign a_in      = req_msg[A_LSB +: DATA_W];
  assign b_in      = req_msg[B_LSB +: DATA_W];
  assign signed_op = (fn_in == MULDIV_DIV) || (fn_in == MULDIV_REM);
  assign a_neg     = signed_op && a_in[DATA_W-1];
  assign b_neg     = signed_op && b_in[DATA_W-1];

  // Bit DATA_W of the 33-bit difference is set exactly when shifted < divisor.
  assign shifted = {acc_reg, a_reg[DATA_W-1]};
  assign sub     = shifted - {1'b0, b_reg};

  // One iteration of either algorithm.
  always_comb begin
    a_nxt   = a_reg;
    b_nxt   = b_reg;
    acc_nxt = acc_reg;
    if (fn_reg == MULDIV_MUL) begin
      acc_nxt = acc_reg + (b_reg[0] ? a_reg : '0);
      a_nxt   = {a_reg[DATA_W-2:0], 1'b0};
      b_nxt   = {1'b0, b_reg[DATA_W-1:1]};
    end else if (!sub[DATA_W]) begin
      acc_nxt = sub[DATA_W-1:0];
      a_nxt   = {a_reg[DATA_W-2:0], 1'b1};
    end else begin
      acc_nxt = shifted[DATA_W-1:0];
      a_nxt   = {a_reg[DATA_W-2:0], 1'b0};
    end
  end

  // Final fixup on the last iteration's values; remainder for b=0 is already a.
  always_comb begin
    result_nxt = '0;
    case (fn_reg)
      MULDIV_MUL:  result_nxt = acc_nxt;
      MULDIV_DIV:  result_nxt = b_zero ? '1 : cond_neg(neg_q, a_nxt);
      MULDIV_DIVU: result_nxt = b_zero ? '1 : a_nxt;
      MULDIV_REM:  result_nxt = cond_neg(neg_r, acc_nxt);
      MULDIV_REMU: result_nxt = acc_nxt;
      default:     result_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (load_c) begin
      a_reg   <= cond_neg(a_neg, a_in);
      b_reg   <= cond_neg(b_neg, b_in);
      acc_reg <= '0;
      fn_reg  <= fn_in;
      neg_q   <= a_neg ^ b_neg;
      neg_r   <= a_neg;
      b_zero  <= (b_in == '0);
    end else if (step_c) begin
      a_reg   <= a_nxt;
      b_reg   <= b_nxt;
      acc_reg <= acc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_msg <= '0;
    end else if (last_c) begin
      resp_msg <= result_nxt;
    end
  end

endmodule

// File: rtl/lab2_proc_muldiv_iter.sv
// Iterative 32-bit multiply/divide unit with val/rdy handshakes; control FSM
// and iteration counter here, arithmetic in the datapath sub-module.
module lab2_proc_muldiv_iter
  import lab2_proc_muldiv_iter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_val,
  output logic              req_rdy,
  input  logic [MSG_W-1:0]  req_msg,
  output logic              resp_val,
  input  logic              resp_rdy,
  output logic [DATA_W-1:0] resp_msg
);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             load_c;
  logic             step_c;
  logic             last_c;

  assign load_c = (state == IDLE) && req_val && req_rdy;
  assign step_c = (state == CALC);
  assign last_c = step_c && (cnt == CNT_W'(DATA_W - 1));

  // Handshake outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      req_rdy  <= 1'b1;
      resp_val <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_c) begin
            state   <= CALC;
            cnt     <= '0;
            req_rdy <= 1'b0;
          end
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (last_c) begin
            state    <= DONE;
            resp_val <= 1'b1;
          end
        end
        DONE: begin
          if (resp_rdy) begin
            state    <= IDLE;
            resp_val <= 1'b0;
            req_rdy  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          req_rdy  <= 1'b1;
          resp_val <= 1'b0;
        end
      endcase
    end
  end

  lab2_proc_muldiv_iter_dpath u_dpath (
    .clk      (clk),
    .reset    (reset),
    .req_msg  (req_msg),
    .load_c   (load_c),
    .step_c   (step_c),
    .last_c   (last_c),
    .resp_msg (resp_msg)
  );

endmodule

// File: tb/tb_lab2_proc_muldiv_iter.sv
// Bench for lab2_proc_muldiv_iter: directed corner cases, backpressure, reset
// abort, then randomized operations against an arithmetic reference model.
module tb_lab2_proc_muldiv_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_val;
  logic        req_rdy;
  logic [66:0] req_msg;
  logic        resp_val;
  logic        resp_rdy;
  logic [31:0] resp_msg;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lab2_proc_muldiv_iter dut (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_msg  (req_msg),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_msg (resp_msg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic with the architectural corner rules.
  function automatic logic [31:0] ref_model(input logic [2:0] fn, input logic [31:0] a,
                                            input logic [31:0] b);
    int  sa;
    int  sb;
    logic ovf;
    sa  = int'(a);
    sb  = int'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (fn)
      3'd0: return a * b;
      3'd1: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'd2: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd3: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      3'd4: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Present a request and let it be taken; returns just after the accept edge.
  task automatic send(input string tag, input logic [2:0] fn, input logic [31:0] a,
                      input logic [31:0] b);
    int guard;
    req_msg = {fn, a, b};
    req_val = 1'b1;
    guard   = 0;
    while (!req_rdy && guard < 100) begin
      tick();
      guard++;
    end
    check({tag, "_accept_rdy"}, 32'(req_rdy), 32'd1);
    tick();
    req_val = 1'b0;
    req_msg = {$urandom_range(0, 7), $urandom, $urandom};
  endtask

  // Wait for resp_val, optionally waving ignored requests during CALC/DONE.
  task automatic wait_resp(input string tag, input bit rnd);
    int lat;
    lat = 0;
    while (!resp_val && lat < 100) begin
      if (rnd) begin
        req_val = 1'($urandom_range(0, 1));
        req_msg = {$urandom_range(0, 7), $urandom, $urandom};
      end
      tick();
      lat++;
    end
    req_val = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'd32);
    check({tag, "_rdy_in_done"}, 32'(req_rdy), 32'd0);
  endtask

  // Accept the response (with optional random stalls) and verify it.
  task automatic drain(input string tag, input logic [31:0] exp, input bit rnd);
    int guard;
    guard    = 0;
    resp_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!resp_rdy && guard < 16) begin
      tick();
      check({tag, "_hold_val"}, 32'(resp_val), 32'd1);
      resp_rdy = 1'($urandom_range(0, 1));
      guard++;
    end
    resp_rdy = 1'b1;
    check({tag, "_result"}, resp_msg, exp);
    tick();
    resp_rdy = 1'b0;
    check({tag, "_val_drop"}, 32'(resp_val), 32'd0);
    check({tag, "_rdy_back"}, 32'(req_rdy), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit rnd);
    if (rnd) repeat ($urandom_range(0, 2)) tick();
    send(tag, fn, a, b);
    wait_resp(tag, rnd);
    drain(tag, exp, rnd);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          seen;
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;

    reset    = 1'b1;
    req_val  = 1'b0;
    req_msg  = '0;
    resp_rdy = 1'b0;
    tick();
    tick();
    check("rst_req_rdy",  32'(req_rdy),  32'd1);
    check("rst_resp_val", 32'(resp_val), 32'd0);
    check("rst_resp_msg", resp_msg,      32'd0);
    reset = 1'b0;
    tick();

    // Directed corner cases.
    run_op("mul_m1x7",   3'd0, 32'hFFFF_FFFF, 32'd7,         32'hFFFF_FFF9, 1'b0);
    run_op("div_m7_2",   3'd1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0);
    run_op("rem_m7_2",   3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0);
    run_op("divu_m7_2",  3'd2, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 1'b0);
    run_op("div_by0",    3'd1, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 1'b0);
    run_op("rem_by0",    3'd3, 32'h1234_5678, 32'd0,         32'h1234_5678, 1'b0);
    run_op("divu_by0",   3'd2, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 1'b0);
    run_op("remu_by0",   3'd4, 32'h1234_5678, 32'd0,         32'h1234_5678, 1'b0);
    run_op("div_ovf",    3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op("rem_ovf",    3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0);
    run_op("reserved",   3'd6, 32'h1234_5678, 32'd3,         32'h0,         1'b0);

    // Backpressure: response held while a second request waits.
    send("bp1", 3'd0, 32'd6, 32'd7);
    wait_resp("bp1", 1'b0);
    req_msg  = {3'd2, 32'd100, 32'd7};
    req_val  = 1'b1;
    resp_rdy = 1'b0;
    repeat (10) begin
      tick();
      check("bp_hold_val", 32'(resp_val), 32'd1);
      check("bp_hold_msg", resp_msg,      32'd42);
      check("bp_hold_rdy", 32'(req_rdy),  32'd0);
    end
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
    check("bp_after_xfer_rdy", 32'(req_rdy),  32'd1);
    check("bp_after_xfer_val", 32'(resp_val), 32'd0);
    tick();
    check("bp_second_taken", 32'(req_rdy), 32'd0);
    req_val = 1'b0;
    wait_resp("bp2", 1'b0);
    drain("bp2", 32'd14, 1'b0);

    // Reset mid-division abandons the operation.
    send("rst_div", 3'd1, 32'hFFFF_FFF9, 32'd2);
    repeat (15) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_req_rdy",  32'(req_rdy),  32'd1);
    check("midrst_resp_val", 32'(resp_val), 32'd0);
    seen     = 1'b0;
    resp_rdy = 1'b1;
    repeat (40) begin
      tick();
      if (resp_val) seen = 1'b1;
    end
    resp_rdy = 1'b0;
    check("midrst_no_ghost", 32'(seen), 32'd0);
    run_op("mul_3x5", 3'd0, 32'd3, 32'd5, 32'd15, 1'b0);

    // Randomized operations with stalls.
    for (int i = 0; i < 1000; i++) begin
      fn = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      a  = pick_operand();
      b  = pick_operand();
      run_op("rand", fn, a, b, ref_model(fn, a, b), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
